// File: rtl/code_seq_ctrl_if.sv
// Code-word output stream between code_seq_ctrl (master) and its consumer (slave).
// Handshake: a word moves on a rising edge where code_valid and code_ready are both high;
// while code_valid is high and code_ready low, code_out and idx_out hold still.
interface code_seq_ctrl_if #(
  parameter int IDX_W  = 3,
  parameter int CODE_W = 2**IDX_W
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code_out;
  logic [IDX_W-1:0]  idx_out;

  modport master (output code_valid, code_out, idx_out, input code_ready);
  modport slave  (input code_valid, code_out, idx_out, output code_ready);
endinterface

// File: rtl/code_seq_ctrl.sv
// Gray/one-hot code sequencer: steps an index over a programmed range and streams the codes.
// Optional CODE_SEQ_CHECK_EN adds a sticky code_err output that flags malformed code words.
module code_seq_ctrl #(
  parameter int IDX_W  = 3,
  parameter int CODE_W = 2**IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_gray,
  input  logic             dir_down,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] last_idx,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg,
`ifdef CODE_SEQ_CHECK_EN
  output logic             code_err,
`endif
  code_seq_ctrl_if.master  code_if
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              dir_q, dir_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [IDX_W-1:0]  nxt_idx;
  logic              xfer;
  logic              start_acc;

  function automatic logic [CODE_W-1:0] enc(input logic [IDX_W-1:0] i, input logic gray);
    logic [CODE_W-1:0] r;
    r = '0;
    if (gray) r[IDX_W-1:0] = i ^ (i >> 1);
    else      r[i] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= '0;
      idx_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
    end
  end

  // Index arithmetic wraps naturally at IDX_W bits in both directions.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    last_d    = last_q;
    idx_d     = idx_q;
    code_d    = code_q;
    start_acc = 1'b0;
    xfer      = (state_q == S_RUN) && code_if.code_ready;
    nxt_idx   = dir_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          mode_d    = mode_gray;
          dir_d     = dir_down;
          last_d    = last_idx;
          idx_d     = first_idx;
          code_d    = enc(first_idx, mode_gray);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over a transfer on the same edge
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d  = nxt_idx;
            code_d = enc(nxt_idx, mode_q);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign code_if.code_valid = (state_q == S_RUN);
  assign code_if.code_out   = code_q;
  assign code_if.idx_out    = idx_q;
  assign busy               = (state_q == S_RUN);
  assign done               = (state_q == S_DONE);
  assign state_dbg          = state_q;

`ifdef CODE_SEQ_CHECK_EN
  // Watches the word as presented on the stream, so any corruption after the register is caught.
  logic              err_q, err_d;
  logic [CODE_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic              mode_bad, step_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  always_comb begin
    err_d      = err_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    mode_bad   = mode_q ? (|(code_if.code_out >> IDX_W)) : ($countones(code_if.code_out) != 1);
    step_bad   = mode_q && prev_vld_q && ($countones(code_if.code_out ^ prev_q) != 1);
    if (start_acc) begin
      err_d      = 1'b0;
      prev_vld_d = 1'b0;
    end else if (code_if.code_valid) begin
      if (mode_bad || step_bad) err_d = 1'b1;
      if (xfer) begin
        prev_d     = code_if.code_out;
        prev_vld_d = 1'b1;
      end
    end
  end

  assign code_err = err_q;
`endif

endmodule

// File: tb/tb_code_seq_ctrl.sv
// Directed bench for code_seq_ctrl: expected words go into a queue, a negedge monitor pops on transfer.
// Define CODE_SEQ_CHECK_EN to also exercise the code_err checker.
module tb_code_seq_ctrl;
  localparam int IDX_W  = 3;
  localparam int CODE_W = 8;
  localparam int W      = IDX_W + CODE_W;

  logic             clk, rst_n, start, abort, mode_gray, dir_down;
  logic [IDX_W-1:0] first_idx, last_idx;
  logic             busy, done;
  logic [1:0]       state_dbg;
`ifdef CODE_SEQ_CHECK_EN
  logic             code_err;
`endif

  code_seq_ctrl_if #(.IDX_W(IDX_W)) cif();

  code_seq_ctrl #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode_gray (mode_gray),
    .dir_down  (dir_down),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
`ifdef CODE_SEQ_CHECK_EN
    .code_err  (code_err),
`endif
    .code_if   (cif)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         done_cnt = 0;
  logic [W-1:0] exp_q[$];
  bit         hold_chk_en = 1'b1;
  bit         stall_q = 1'b0;
  logic [W-1:0] held_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [IDX_W-1:0] i, input logic [CODE_W-1:0] c);
    exp_q.push_back({i, c});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] word;
    word = {cif.idx_out, cif.code_out};
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (cif.code_valid && stall_q && hold_chk_en) check("hold_stable", word, held_word);
      if (cif.code_valid && cif.code_ready) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_word: got 0x%0h expected none", word);
        end else begin
          check("word", word, exp_q.pop_front());
        end
      end
      stall_q   = cif.code_valid && !cif.code_ready;
      held_word = word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic g, input logic d, input logic [IDX_W-1:0] f,
                          input logic [IDX_W-1:0] l, input logic with_abort);
    @(posedge clk); #1;
    mode_gray = g; dir_down = d; first_idx = f; last_idx = l;
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    // scramble run parameters; the latched copies must be unaffected
    mode_gray = 1'($urandom_range(0, 1));
    dir_down  = 1'($urandom_range(0, 1));
    first_idx = 3'($urandom_range(0, 7));
    last_idx  = 3'($urandom_range(0, 7));
    @(negedge clk);
    check("start_valid", cif.code_valid, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic wait_done(input bit toggle, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (cycles < 60 && !seen) begin
      @(posedge clk); #1;
      if (toggle) cif.code_ready = (cycles % 3 == 0);
      cycles++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_busy_low", busy, 0);
      check("done_valid_low", cif.code_valid, 0);
      check("words_drained", exp_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, cif.code_valid, 0);
    check({tag, "_code"}, cif.code_out, 0);
    check({tag, "_idx"}, cif.idx_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int d0;
    logic [CODE_W-1:0] gray_tab [8];
    gray_tab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_gray = 1'b0; dir_down = 1'b0;
    first_idx = '0; last_idx = '0; cif.code_ready = 1'b0;
    #12;
    check_outputs_zero("reset");
    check("reset_state", state_dbg, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Gray, up, full range
    cif.code_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(3'(i), gray_tab[i]);
    do_start(1'b1, 1'b0, 3'd0, 3'd7, 1'b0);
    wait_done(1'b0, cyc);
    check("gray_full_done_latency", cyc, 8);

    // One-hot, down, 2 -> 6 through the wrap
    push(3'd2, 8'h04); push(3'd1, 8'h02); push(3'd0, 8'h01); push(3'd7, 8'h80); push(3'd6, 8'h40);
    do_start(1'b0, 1'b1, 3'd2, 3'd6, 1'b0);
    wait_done(1'b0, cyc);
    check("onehot_down_done_latency", cyc, 5);

    // Gray, up, 0 -> 3 with backpressure
    push(3'd0, 8'h00); push(3'd1, 8'h01); push(3'd2, 8'h03); push(3'd3, 8'h02);
    do_start(1'b1, 1'b0, 3'd0, 3'd3, 1'b0);
    wait_done(1'b1, cyc);
    cif.code_ready = 1'b1;

    // Gray, up, 6 -> 1 wrap
    push(3'd6, 8'h05); push(3'd7, 8'h04); push(3'd0, 8'h00); push(3'd1, 8'h01);
    do_start(1'b1, 1'b0, 3'd6, 3'd1, 1'b0);
    wait_done(1'b0, cyc);

    // Abort on the 3rd valid cycle; that word is still taken by the consumer
    push(3'd0, 8'h00); push(3'd1, 8'h01); push(3'd2, 8'h03);
    do_start(1'b1, 1'b0, 3'd0, 3'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_valid", cif.code_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (4) @(negedge clk);
    check("abort_no_done_pulse", done_cnt, d0);
    check("abort_drained", exp_q.size(), 0);
    push(3'd0, 8'h00); push(3'd1, 8'h01); push(3'd2, 8'h03);
    do_start(1'b1, 1'b0, 3'd0, 3'd2, 1'b0);
    wait_done(1'b0, cyc);

    // first == last, one-hot, with abort raised together with start
    push(3'd5, 8'h20);
    do_start(1'b0, 1'b0, 3'd5, 3'd5, 1'b1);
    wait_done(1'b0, cyc);
    check("single_word_done_latency", cyc, 1);

    // Reset in the middle of a stalled run
    cif.code_ready = 1'b0;
    do_start(1'b1, 1'b0, 3'd3, 3'd7, 1'b0);
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    @(posedge clk); #1 rst_n = 1'b1;

`ifdef CODE_SEQ_CHECK_EN
    cif.code_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(3'(i), gray_tab[i]);
    do_start(1'b1, 1'b0, 3'd0, 3'd7, 1'b0);
    wait_done(1'b0, cyc);
    check("code_err_clean_run", code_err, 0);

    cif.code_ready = 1'b0;
    do_start(1'b1, 1'b0, 3'd0, 3'd7, 1'b0);
    hold_chk_en = 1'b0;
    @(posedge clk); #1 force cif.code_out = 8'h10;
    @(posedge clk); #1 release cif.code_out;
    @(negedge clk);
    check("code_err_set", code_err, 1);
    repeat (3) @(negedge clk);
    check("code_err_sticky", code_err, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    hold_chk_en = 1'b1;
    check("code_err_after_abort", code_err, 1);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
